sdm_bitstream_gen: RTL and testbench
====================================

Name: sdm_bitstream_gen

Overview:
- First-order sigma-delta modulator. Converts 8-bit unsigned sample codes into the 1-bit oversampled stream consumed by the decimating filter stage (its IN).
- Each accepted sample is held for OSR clocks, called a "frame". Ones density over a frame is approximately D/2^DATA_W.
- Samples arrive through a valid/ready handshake into a 2-entry FIFO.
- Emits a frame strobe so the downstream decimator can align to frames.

Parameters:
- DATA_W, 8: sample code width. Accumulator is DATA_W+1 bits.
- OSR, 64: clocks per frame (≥2).
- FIFO_DEPTH, 2: input sample FIFO entries. Fixed at 2 for this revision.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- EN  in  1  run enable
- IN_DATA  in  DATA_W  unsigned sample code D
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  FIFO can accept
- OUT  out  1  modulator bitstream (registered)
- FRAME_STROBE  out  1  high with the first OUT bit of each frame
- UNDERRUN  out  1  1-cycle pulse: frame boundary reached with FIFO empty
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (RST=0, async):
  - OUT, FRAME_STROBE, UNDERRUN = 0; BUSY = 0; IN_READY = 1 after release.
  - FIFO emptied; acc = 0; cur = 0; frame_cnt = 0; state = IDLE.
- Handshake:
  - Push on edge with IN_VALID & IN_READY.
  - IN_READY = (count < 2), combinational from count only. A same-cycle pop does not free a slot; no pass-through.
  - IN_DATA may change freely when IN_VALID is low.
- States: IDLE, RUN, STOP.
- IDLE:
  - OUT = 0, acc held at 0.
  - On an edge with EN=1 and FIFO non-empty: pop into cur, frame_cnt <= 0, acc <= 0, go to RUN.
  - A push into an empty FIFO at edge a gives: pop at edge a+1, first OUT bit at edge a+2.
- RUN and STOP, every edge:
  - sum = {1'b0, acc[DATA_W-1:0]} + cur.
  - OUT <= sum[DATA_W]; acc <= sum[DATA_W-1:0].
  - FRAME_STROBE <= (frame_cnt == 0); frame_cnt <= frame_cnt + 1.
- Frame boundary (frame_cnt == OSR-1): frame_cnt <= 0. This bit still uses the old cur. Then:
  - RUN, EN=1, FIFO non-empty: pop, cur <= head.
  - RUN, EN=1, FIFO empty: cur held, UNDERRUN <= 1 for one cycle, next frame replays the last sample.
  - RUN with EN=0, or STOP: go to IDLE; OUT <= 0 from the next cycle; acc <= 0; FIFO contents retained.
- RUN → STOP when EN=0 mid-frame. The current frame always completes; a frame is never truncated. EN re-asserted during STOP is ignored until IDLE.
- acc persists across frames within a run. Carry-out is the only quantizer; no saturation needed (sum ≤ 2^(DATA_W+1)-2).
- Simultaneous push and pop: count unchanged, ordering preserved.
- D = 0: all zeros. D = 2^DATA_W-1: one zero per 2^DATA_W bits.
- EN toggling in IDLE with an empty FIFO: no state change.

Decomposition:
- Package sdm_pkg:
  - state enum {IDLE, RUN, STOP}
  - default DATA_W/OSR constants
  - frame counter width $clog2(OSR)
- Sub-module sdm_sample_fifo:
  - 2-entry synchronous FIFO with push/pop/count/head.
  - Same CLK and RST (async, active-low); count cleared on reset.
- Top holds the FSM, accumulator, frame counter and output registers.

Test Plan:
- D=128, OSR=64, EN=1, single sample: first OUT at edge a+2; OUT = 0,1,0,1,…; FRAME_STROBE high on the first bit only; 32 ones in the frame.
- D=64: ones at bit 4, 8, …, 64 of the frame (16 per frame). Then no second sample → UNDERRUN pulses once at the boundary, the next frame repeats the same pattern, BUSY stays 1.
- D=0 then D=255 back-to-back: frame 1 has 0 ones. Frame 2 has 63 ones (floor(64·255/256)) and starts with no idle gap.
- Backpressure: push 3 samples on consecutive cycles while IDLE with EN=0 → IN_READY falls after 2 pushes, 3rd held. Then EN=1 → 3rd accepted the cycle after the first pop; frames play in push order.
- EN dropped at frame bit 10: frame runs to bit 64; BUSY falls the edge after; OUT=0 thereafter; queued sample remains, count unchanged.
- RST asserted mid-frame: OUT/FRAME_STROBE/UNDERRUN/BUSY go 0 immediately; after release IN_READY=1, FIFO empty, no OUT activity until a new push.

Source files
------------

// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_pkg
//  Description : Shared types and defaults for the sigma-delta bitstream
//                generator: FSM state encoding, default geometry, and the
//                frame counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdm_pkg;

  // Default geometry of the modulator
  localparam int SDM_DATA_W     = 8;
  localparam int SDM_OSR        = 64;
  localparam int SDM_FIFO_DEPTH = 2;

  // Modulator run state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sdm_state_e;

  // Width of a counter that must reach osr-1; never narrower than one bit
  function automatic int frame_cnt_width(input int osr);
    return (osr > 1) ? $clog2(osr) : 1;
  endfunction

endpackage : sdm_pkg
`default_nettype wire

// File: rtl/sdm_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_sample_fifo
//  Description : Small synchronous sample FIFO with push/pop, occupancy count
//                and a combinational head-of-queue read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdm_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Requests against a full/empty queue are dropped so occupancy never wraps
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop  && (count != '0);
  assign head    = mem[rd_ptr];

  // Circular pointer advance that also works for non power-of-two depths
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push+pop together leaves count as is
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample storage; cleared on reset so the head port never shows stale X
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule : sdm_sample_fifo
`default_nettype wire

// File: rtl/sdm_bitstream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_bitstream_gen
//  Description : First-order sigma-delta modulator. Each accepted sample is
//                held for OSR clocks (one frame) while a carry-out quantizer
//                produces a 1-bit stream whose ones density tracks
//                D / 2^DATA_W. Samples arrive over valid/ready into a small
//                FIFO; a strobe marks the first bit of every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdm_bitstream_gen
  import sdm_pkg::*;
#(
  parameter int DATA_W     = SDM_DATA_W,
  parameter int OSR        = SDM_OSR,
  parameter int FIFO_DEPTH = SDM_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              OUT,
  output logic              FRAME_STROBE,
  output logic              UNDERRUN,
  output logic              BUSY
);

  localparam int                CNT_W    = frame_cnt_width(OSR);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OSR - 1);
  localparam int                FCNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [FCNT_W-1:0] FIFO_CAP = FCNT_W'(FIFO_DEPTH);

  sdm_state_e        state;
  logic [DATA_W-1:0] acc;        // residue; the carry of sum is the output bit
  logic [DATA_W-1:0] cur;        // sample currently being played
  logic [CNT_W-1:0]  frame_cnt;
  logic [DATA_W:0]   sum;
  logic              at_last;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;

  // ---------------------------------------------------------------------------
  // Input sample queue
  // ---------------------------------------------------------------------------
  sdm_sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (IN_DATA),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Ready depends on occupancy alone: a slot freed by a same-cycle pop is
  // not offered until the next cycle, which keeps ready free of FSM paths.
  assign IN_READY   = (fifo_count < FIFO_CAP);
  assign push       = IN_VALID && IN_READY;
  assign fifo_empty = (fifo_count == '0);

  // ---------------------------------------------------------------------------
  // Modulator datapath
  // ---------------------------------------------------------------------------
  // Both operands are below 2^DATA_W, so the DATA_W+1 bit sum cannot overflow
  // and its top bit is the quantizer decision.
  assign sum     = {1'b0, acc} + {1'b0, cur};
  assign at_last = (frame_cnt == LAST_CNT);

  // Decide when the FSM takes the head sample: start of a run, or a frame
  // boundary while still enabled with data waiting.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = EN && !fifo_empty;
      RUN:     pop = at_last && EN && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, accumulator, frame counter and registered outputs
  // ---------------------------------------------------------------------------
  // Frames are never truncated: dropping EN mid-frame parks in STOP and the
  // return to IDLE happens only on the last bit of the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      acc          <= '0;
      cur          <= '0;
      frame_cnt    <= '0;
      OUT          <= 1'b0;
      FRAME_STROBE <= 1'b0;
      UNDERRUN     <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      UNDERRUN <= 1'b0;
      case (state)
        IDLE: begin
          OUT          <= 1'b0;
          FRAME_STROBE <= 1'b0;
          acc          <= '0;
          if (EN && !fifo_empty) begin
            cur       <= fifo_head;
            frame_cnt <= '0;
            state     <= RUN;
            BUSY      <= 1'b1;
          end
        end

        RUN, STOP: begin
          OUT          <= sum[DATA_W];
          acc          <= sum[DATA_W-1:0];
          FRAME_STROBE <= (frame_cnt == '0);
          frame_cnt    <= frame_cnt + CNT_W'(1);
          if (at_last) begin
            // Last bit of the frame was produced above with the old sample
            frame_cnt <= '0;
            if ((state == RUN) && EN) begin
              if (!fifo_empty) begin
                cur <= fifo_head;
              end else begin
                // Nothing queued: keep replaying the current sample
                UNDERRUN <= 1'b1;
              end
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
              acc   <= '0;
            end
          end else if ((state == RUN) && !EN) begin
            state <= STOP;
          end
        end

        default: begin
          state        <= IDLE;
          BUSY         <= 1'b0;
          OUT          <= 1'b0;
          FRAME_STROBE <= 1'b0;
          acc          <= '0;
        end
      endcase
    end
  end

endmodule : sdm_bitstream_gen
`default_nettype wire

// File: tb/tb_sdm_bitstream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdm_bitstream_gen
//  Description : Directed self-checking bench for sdm_bitstream_gen with the
//                default geometry (DATA_W=8, OSR=64, FIFO_DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdm_bitstream_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic       OUT;
  logic       FRAME_STROBE;
  logic       UNDERRUN;
  logic       BUSY;

  int passed = 0;
  int total  = 0;

  // Per-frame capture
  logic bits [64];
  logic strb [64];
  logic und  [64];
  int   ones;
  int   strobes;
  int   unds;
  int   busy_lo;
  int   mism64;
  int   activity;

  sdm_bitstream_gen dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .IN_DATA      (IN_DATA),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .OUT          (OUT),
    .FRAME_STROBE (FRAME_STROBE),
    .UNDERRUN     (UNDERRUN),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Clock one whole frame (64 bits), optionally dropping EN or pushing a
  // sample before the edge that produces bit index drop_idx / push_idx.
  task automatic run_frame(input int drop_idx, input int push_idx, input logic [7:0] push_val);
    ones = 0; strobes = 0; unds = 0; busy_lo = 0; mism64 = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == drop_idx) EN = 1'b0;
      if (i == push_idx) begin
        IN_VALID = 1'b1;
        IN_DATA  = push_val;
      end else begin
        IN_VALID = 1'b0;
      end
      tick();
      bits[i] = OUT;
      strb[i] = FRAME_STROBE;
      und[i]  = UNDERRUN;
      ones    += int'(OUT);
      strobes += int'(FRAME_STROBE);
      unds    += int'(UNDERRUN);
      if (i < 63 && !BUSY) busy_lo++;
      if (OUT != ((i % 4) == 3)) mism64++;
    end
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'd0;
    tick(); tick();
    check("rst_out",    OUT,          1'b0);
    check("rst_strobe", FRAME_STROBE, 1'b0);
    check("rst_under",  UNDERRUN,     1'b0);
    check("rst_busy",   BUSY,         1'b0);
    RST = 1'b1;
    tick();
    check("rst_ready",  IN_READY,     1'b1);

    // EN toggling while idle and empty does nothing
    EN = 1'b1; tick(); EN = 1'b0; tick(); EN = 1'b1; tick();
    check("idle_toggle_busy", BUSY, 1'b0);
    check("idle_toggle_out",  OUT,  1'b0);

    // Push D=128 at edge a; at edge a+1 pop it while pushing D=64
    IN_VALID = 1'b1; IN_DATA = 8'd128;
    tick();
    check("push_a_busy",  BUSY,     1'b0);
    check("push_a_ready", IN_READY, 1'b1);
    IN_DATA = 8'd64;
    tick();
    check("pop_busy",   BUSY,         1'b1);
    check("pop_out",    OUT,          1'b0);
    check("pop_strobe", FRAME_STROBE, 1'b0);
    check("pop_ready",  IN_READY,     1'b1);

    // Frame of D=128: 0,1,0,1,... first OUT bit at edge a+2
    run_frame(-1, -1, 8'd0);
    check("f128_bit0",    bits[0], 1'b0);
    check("f128_bit1",    bits[1], 1'b1);
    check("f128_ones",    ones,    32);
    check("f128_strb0",   strb[0], 1'b1);
    check("f128_strobes", strobes, 1);
    check("f128_unds",    unds,    0);

    // Frame of D=64: ones on every 4th bit, FIFO now empty -> underrun
    run_frame(-1, -1, 8'd0);
    check("f64_ones",    ones,    16);
    check("f64_pattern", mism64,  0);
    check("f64_strb0",   strb[0], 1'b1);
    check("f64_und63",   und[63], 1'b1);
    check("f64_unds",    unds,    1);
    check("f64_busy",    busy_lo, 0);

    // Replayed D=64 frame; queue D=200 at bit 5, drop EN at bit 10
    run_frame(10, 5, 8'd200);
    check("rep_ones",    ones,    16);
    check("rep_pattern", mism64,  0);
    check("rep_strb0",   strb[0], 1'b1);
    check("rep_unds",    unds,    0);
    check("rep_busy",    busy_lo, 0);
    tick();
    check("stop_busy",   BUSY,         1'b0);
    check("stop_out",    OUT,          1'b0);
    check("stop_strobe", FRAME_STROBE, 1'b0);
    check("stop_ready",  IN_READY,     1'b1);

    // Backpressure: second push fills the FIFO, third is held off
    IN_VALID = 1'b1; IN_DATA = 8'd0;
    tick();
    check("bp_full_ready", IN_READY, 1'b0);
    IN_DATA = 8'd255;
    tick(); tick();
    check("bp_held_ready", IN_READY, 1'b0);
    check("bp_held_busy",  BUSY,     1'b0);
    EN = 1'b1;
    tick();
    check("bp_pop_busy",  BUSY,     1'b1);
    check("bp_pop_ready", IN_READY, 1'b1);

    // D=200 frame; held D=255 is accepted on its first bit
    run_frame(-1, 0, 8'd255);
    check("f200_ones",  ones,    50);
    check("f200_strb0", strb[0], 1'b1);
    check("f200_unds",  unds,    0);

    // D=0 then D=255 back to back
    run_frame(-1, -1, 8'd0);
    check("f0_ones",  ones,    0);
    check("f0_strb0", strb[0], 1'b1);
    run_frame(-1, -1, 8'd0);
    check("f255_ones",    ones,    63);
    check("f255_strb0",   strb[0], 1'b1);
    check("f255_strobes", strobes, 1);
    check("f255_und63",   und[63], 1'b1);

    // Mid-frame of the D=255 replay (residue 192 carried over -> all ones)
    repeat (20) tick();
    check("mid_out",  OUT,  1'b1);
    check("mid_busy", BUSY, 1'b1);
    RST = 1'b0;
    #1;
    check("arst_out",    OUT,          1'b0);
    check("arst_strobe", FRAME_STROBE, 1'b0);
    check("arst_under",  UNDERRUN,     1'b0);
    check("arst_busy",   BUSY,         1'b0);
    tick();
    RST = 1'b1;
    tick();
    check("post_ready", IN_READY, 1'b1);
    check("post_busy",  BUSY,     1'b0);
    activity = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (OUT || BUSY || FRAME_STROBE || UNDERRUN) activity++;
    end
    check("post_quiet", activity, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sdm_bitstream_gen
`default_nettype wire
